instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_if.sv | 32 +++
 rtl/instruction_fetch_buffer.sv | 72 +++++++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg : opcodes, NOP word and fetch FSM encoding      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

    localparam int INSTR_WIDTH = 20;

    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 20'h00000;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
        return word[INSTR_WIDTH-1 -: 4] == OP_HALT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_if : imem request channel and IF/ID stage signals   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 8
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   stall;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [PC_WIDTH-1:0]    instr_pc;

    modport master (
        output imem_req, imem_addr, instruction, instr_valid, instr_pc,
        input  imem_ack, imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_valid, instr_pc,
        output imem_ack, imem_data, stall, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_buffer : 2-entry in-order FIFO with push/pop/flush              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_buffer #(
    parameter int WIDTH = 28
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    input  wire logic             flush,
    output logic      [WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic      [1:0]       count
);
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                entry0_d = entry1_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            // New word lands in the first slot free after this cycle's pop.
            if (do_push) begin
                if ((count_q - {1'b0, do_pop}) == 2'd0) begin
                    entry0_d = push_data;
                end else begin
                    entry1_d = push_data;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_data = entry0_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : PC sequencing, imem handshake, IF/ID buffering    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                     PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
    input  wire logic          clock,
    input  wire logic          reset,
    instruction_fetch_if.master bus
);
    localparam int ENTRY_WIDTH = PC_WIDTH + INSTR_WIDTH;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;
    logic                active_q;

    logic [ENTRY_WIDTH-1:0] head_data;
    logic                   buf_full;
    logic                   buf_empty;
    logic [1:0]             buf_count;

    logic                pop;
    logic                room;
    logic                req;
    logic [PC_WIDTH-1:0] addr;
    logic                ack_take;
    logic                push;

    always_comb begin
        pop  = !buf_empty && !bus.stall && !bus.redirect;
        room = !buf_full || pop;
        req  = 1'b0;
        addr = fetch_pc_q;
        case (state_q)
            S_RUN:   req = active_q && room;
            S_DRAIN: begin
                req  = 1'b1;
                addr = drain_addr_q;
            end
            default: req = 1'b0;
        endcase
        ack_take = req && bus.imem_ack;
        push     = (state_q == S_RUN) && ack_take && !bus.redirect;
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            case (state_q)
                S_RUN: begin
                    // A request already seen by memory must finish at its old address.
                    if (req && !bus.imem_ack) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end
                end
                S_DRAIN: if (bus.imem_ack) state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end else begin
            case (state_q)
                S_RUN: begin
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
                        if (is_halt(bus.imem_data)) state_d = S_HALT;
                    end
                end
                S_DRAIN: if (bus.imem_ack) state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_RUN;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            active_q     <= 1'b1;
        end
    end

    fetch_buffer #(
        .WIDTH (ENTRY_WIDTH)
    ) u_fetch_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({fetch_pc_q, bus.imem_data}),
        .pop       (pop),
        .flush     (bus.redirect),
        .head_data (head_data),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr;
    assign bus.instr_valid = (buf_count != 2'd0);
    assign bus.instruction = buf_empty ? NOP_INSTR : head_data[INSTR_WIDTH-1:0];
    assign bus.instr_pc    = buf_empty ? '0 : head_data[ENTRY_WIDTH-1:INSTR_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch : directed self-checking bench for the IF stage  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    instruction_fetch_if #(.PC_WIDTH(8)) bus ();

    instruction_fetch #(
        .PC_WIDTH  (8),
        .RESET_PC  (8'h00),
        .NOP_INSTR (20'h00000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;
    int         latency     = 0;
    int         wait_cnt    = 0;
    logic       halt_en     = 1'b0;
    logic [7:0] halt_addr   = 8'h00;

    // Memory model: word = {opcode, 8'h00, addr}; ack after `latency` waiting cycles.
    always_ff @(posedge clock) begin
        if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        bus.imem_ack  = 1'b0;
        if (bus.imem_req) bus.imem_ack = (latency == 0) ? 1'b1 : (wait_cnt == latency);
        bus.imem_data = {((halt_en && (bus.imem_addr == halt_addr)) ? 4'hF : 4'h0),
                         8'h00, bus.imem_addr};
    end

    function automatic logic [19:0] word_of(input logic [7:0] a, input logic h);
        return {(h ? 4'hF : 4'h0), 8'h00, a};
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
        repeat (2) next_cycle();
        #1;
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.instruction !== 20'h00000) begin miscompares++; $display("FAIL rst_instr: got %h want 00000", bus.instruction); end
        vectors++; if (bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc: got %h want 00", bus.instr_pc); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        #1;
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL seq_req_c0: got %b want 0", bus.imem_req); end
        next_cycle(); #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL seq_req_c1: got %b/%h want 1/00", bus.imem_req, bus.imem_addr); end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq_valid_c1: got %b want 0", bus.instr_valid); end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin miscompares++; $display("FAIL seq_pc%0d: got %b/%h want 1/%h", i, bus.instr_valid, bus.instr_pc, 8'(i)); end
            vectors++; if (bus.instruction !== word_of(8'(i), 1'b0)) begin miscompares++; $display("FAIL seq_word%0d: got %h want %h", i, bus.instruction, word_of(8'(i), 1'b0)); end
        end
    endtask

    task automatic test_stall();
        next_cycle(); bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h30; #1;
        next_cycle(); bus.redirect = 1'b0; #1;
        vectors++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h30) begin miscompares++; $display("FAIL stall_s1: got v%b r%b a%h want v0 r1 a30", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        vectors++; if (bus.instr_pc !== 8'h30 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h31) begin miscompares++; $display("FAIL stall_s2: got pc%h r%b a%h want pc30 r1 a31", bus.instr_pc, bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            vectors++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h30) begin miscompares++; $display("FAIL stall_full%0d: got r%b v%b pc%h want r0 v1 pc30", k, bus.imem_req, bus.instr_valid, bus.instr_pc); end
        end
        next_cycle(); bus.stall = 1'b0; #1;
        vectors++; if (bus.instr_pc !== 8'h30 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h32) begin miscompares++; $display("FAIL stall_release: got pc%h r%b a%h want pc30 r1 a32", bus.instr_pc, bus.imem_req, bus.imem_addr); end
        for (int i = 1; i < 4; i++) begin
            next_cycle(); #1;
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(8'h30 + i)) begin miscompares++; $display("FAIL stall_order%0d: got %b/%h want 1/%h", i, bus.instr_valid, bus.instr_pc, 8'(8'h30 + i)); end
        end
    endtask

    task automatic test_drain();
        next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'h05; #1;
        next_cycle(); bus.redirect = 1'b0; latency = 3; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h05 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_t1: got r%b a%h v%b want r1 a05 v0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'h40; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h05) begin miscompares++; $display("FAIL drain_t2: got r%b a%h want r1 a05", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); bus.redirect = 1'b0; #1;
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h05 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_hold%0d: got r%b a%h v%b want r1 a05 v0", k, bus.imem_req, bus.imem_addr, bus.instr_valid); end
        end
        next_cycle(); #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_t5: got r%b a%h v%b want r1 a40 v0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_gap%0d: got v%b pc%h want v0", k, bus.instr_valid, bus.instr_pc); end
        end
        next_cycle(); #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40) begin miscompares++; $display("FAIL drain_first: got %b/%h want 1/40", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_redirect_on_ack();
        next_cycle(); #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h41) begin miscompares++; $display("FAIL rack_wait: got r%b a%h want r1 a41", bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'h10; bus.stall = 1'b1; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h41) begin miscompares++; $display("FAIL rack_req: got r%b a%h want r1 a41", bus.imem_req, bus.imem_addr); end
        next_cycle(); bus.redirect = 1'b0; bus.stall = 1'b0; latency = 0; #1;
        vectors++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 20'h00000) begin miscompares++; $display("FAIL rack_flush: got v%b i%h want v0 i00000", bus.instr_valid, bus.instruction); end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10) begin miscompares++; $display("FAIL rack_refetch: got r%b a%h want r1 a10", bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h10) begin miscompares++; $display("FAIL rack_first: got %b/%h want 1/10", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_halt();
        next_cycle(); halt_en = 1'b1; halt_addr = 8'h03; bus.redirect = 1'b1; bus.redirect_pc = 8'h00; #1;
        next_cycle(); bus.redirect = 1'b0; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_h1: got r%b a%h v%b want r1 a00 v0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin miscompares++; $display("FAIL halt_pc%0d: got %b/%h want 1/%h", i, bus.instr_valid, bus.instr_pc, 8'(i)); end
        end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03) begin miscompares++; $display("FAIL halt_req3: got r%b a%h want r1 a03", bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h03 || bus.instruction !== word_of(8'h03, 1'b1)) begin miscompares++; $display("FAIL halt_word: got v%b pc%h i%h want v1 pc03 i%h", bus.instr_valid, bus.instr_pc, bus.instruction, word_of(8'h03, 1'b1)); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_req_off: got %b want 0", bus.imem_req); end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            vectors++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_idle%0d: got r%b v%b want r0 v0", k, bus.imem_req, bus.instr_valid); end
        end
        next_cycle(); halt_en = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 8'h20; #1;
        next_cycle(); bus.redirect = 1'b0; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h20 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_resume_req: got r%b a%h v%b want r1 a20 v0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
        next_cycle(); #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h20) begin miscompares++; $display("FAIL halt_resume_pc: got %b/%h want 1/20", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_wrap_and_reset();
        next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'hFF; #1;
        next_cycle(); bus.redirect = 1'b0; #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'hFF) begin miscompares++; $display("FAIL wrap_req: got r%b a%h want r1 aFF", bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        vectors++; if (bus.instr_pc !== 8'hFF || bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL wrap_ff: got pc%h a%h want pcFF a00", bus.instr_pc, bus.imem_addr); end
        next_cycle(); latency = 3; bus.stall = 1'b1; #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL wrap_00: got %b/%h want 1/00", bus.instr_valid, bus.instr_pc); end
        next_cycle(); reset = 1'b0; #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin miscompares++; $display("FAIL mid_req: got v%b r%b a%h want v1 r1 a01", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        next_cycle(); reset = 1'b1; latency = 0; bus.stall = 1'b0; #1;
        vectors++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst2_ctl: got v%b r%b want v0 r0", bus.instr_valid, bus.imem_req); end
        vectors++; if (bus.instruction !== 20'h00000 || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL rst2_data: got i%h pc%h want i00000 pc00", bus.instruction, bus.instr_pc); end
        next_cycle(); #1;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL rst2_refetch: got r%b a%h want r1 a00", bus.imem_req, bus.imem_addr); end
        next_cycle(); #1;
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL rst2_first: got %b/%h want 1/00", bus.instr_valid, bus.instr_pc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_drain();
        test_redirect_on_ack();
        test_halt();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
